patch_row_sum_collector: RTL and testbench
==========================================

PATCH_ROW_SUM_COLLECTOR -- requirements
Module: patch_row_sum_collector

Interface
REQ-001 Parameter FP_SIZE, default 32: width of one floating-point row sum.
REQ-002 Parameter N_PATCH_REDUCER, default 4: number of row reducers feeding the block, at least 2.
REQ-003 Parameter N_REDUCER_SIZE, default 2: width of a reducer index, equal to log2(N_PATCH_REDUCER).
REQ-004 dram_clk  in  1  sole clock; every register updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sum_rdy  in  N_PATCH_REDUCER  bit i is a one-cycle pulse: reducer i presents its finished row sum.
REQ-007 sums  in  N_PATCH_REDUCER*FP_SIZE  slice i (bits i*FP_SIZE upward) is reducer i's sum, valid only while sum_rdy[i]=1.
REQ-008 out_valid  out  1  the out_sum/out_id pair is valid.
REQ-009 out_sum  out  FP_SIZE  captured row sum.
REQ-010 out_id  out  N_REDUCER_SIZE  index of the reducer that produced out_sum.
REQ-011 out_ack  in  1  consumer accepts the current output word.
REQ-012 overflow  out  1  sticky flag: a row sum was lost.
REQ-013 idle  out  1  no capture slot pending and out_valid=0.

Function
REQ-014 One capture slot per reducer (FP_SIZE value plus pending bit); a cycle with sum_rdy[i]=1 and slot i empty loads sums slice i and sets pending[i].
REQ-015 sum_rdy[i]=1 while pending[i]=1 and slot i not granted that cycle: old value kept, new value dropped, overflow set.
REQ-016 Grant is possible in a cycle when out_valid=0, or out_valid=1 and out_ack=1.
REQ-017 When a grant is possible and any slot is pending, grant the first pending index at or after rr_ptr, searching upward modulo N_PATCH_REDUCER.
REQ-018 On grant: the next edge loads out_sum/out_id from the granted slot, sets out_valid, clears pending for that slot, and sets rr_ptr to (granted index + 1) mod N_PATCH_REDUCER.
REQ-019 Same-cycle grant and sum_rdy on the same index: the slot reloads with the new value, pending stays 1, and overflow is not set.
REQ-020 out_ack=1 with no grant in that cycle: clears out_valid at the next edge.
REQ-021 out_ack while out_valid=0: ignored.
REQ-022 out_sum and out_id hold stable while out_valid=1 and out_ack=0.
REQ-023 Latency: a sum_rdy pulse at edge t, with an empty output and no competing slot, gives out_valid=1 at edge t+2, i.e. capture at t+1 and output load at t+2.
REQ-024 Full-throughput rule: with out_ack held at 1, one word is delivered per cycle.
REQ-025 Simultaneous pulses on all reducers are captured in the same cycle with no loss.
REQ-026 Reducer sums are not modified; no arithmetic is applied to them.
REQ-027 idle = (pending == 0) and not out_valid, computed combinationally.

Reset
REQ-028 During reset: out_valid=0, out_sum=0, out_id=0, overflow=0, all pending=0, rr_ptr=0; sum_rdy is ignored in the reset cycle.
REQ-029 Reset asserted mid-operation discards all captured and pending sums; no word is emitted after reset until a new sum_rdy arrives.
REQ-030 overflow clears only by reset.

Structure
REQ-031 Shared package holds FP_SIZE, the reducer count and the log2 function; the block uses the same log2 function as the reducers.
REQ-032 One sub-module, rr_arbiter: pending vector and rr_ptr in, one-hot grant plus encoded index out, purely combinational.
REQ-033 Capture slots, output register, rr_ptr and overflow live in the top module.

Verification
REQ-034 Single pulse: sum_rdy=4'b0010, sums slice1=32'h3F800000, out_ack=1 -> out_valid exactly 2 edges later, out_id=1, out_sum=32'h3F800000, one word.
REQ-035 All four pulse together, out_ack=1, rr_ptr=0 -> out_id sequence 0,1,2,3 on consecutive cycles, idle=1 afterward.
REQ-036 Back-pressure: out_ack=0 for 10 cycles after a capture -> out_sum/out_id stable and pending words retained; release out_ack -> every word delivered, overflow=0.
REQ-037 Loss: out_ack=0, reducer 2 pulses twice 5 cycles apart -> overflow=1; the first value is delivered and the second is never delivered.
REQ-038 Same-cycle grant and re-pulse on index 0 -> both values delivered in order, overflow=0.
REQ-039 Reset asserted with 3 slots pending -> out_valid=0, idle=1 next cycle, no output until the next sum_rdy.

Source files
------------

// File: rtl/patch_row_sum_collector_pkg.sv
// Shared sizing constants for the patch row-reduction path, and the log2 helper
// used to size reducer indices identically across the reducers and the collector.
package patch_row_sum_collector_pkg;

  localparam int PRSC_FP_SIZE   = 32;
  localparam int PRSC_N_REDUCER = 4;

  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/patch_row_sum_collector_rr_arbiter.sv
// Combinational round-robin pick: first pending index at or after rr_ptr_i,
// wrapping modulo N_PATCH_REDUCER.
module rr_arbiter
  import patch_row_sum_collector_pkg::*;
#(
  parameter int N_PATCH_REDUCER = PRSC_N_REDUCER,
  parameter int N_REDUCER_SIZE  = log2_ceil(N_PATCH_REDUCER)
) (
  input  logic [N_PATCH_REDUCER-1:0] pending_i,
  input  logic [N_REDUCER_SIZE-1:0]  rr_ptr_i,
  output logic [N_PATCH_REDUCER-1:0] grant_o,
  output logic [N_REDUCER_SIZE-1:0]  grant_idx_o,
  output logic                       grant_any_o
);

  int cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    cand        = 0;
    for (int k = 0; k < N_PATCH_REDUCER; k++) begin
      cand = (int'(rr_ptr_i) + k) % N_PATCH_REDUCER;
      if (!grant_any_o && pending_i[cand]) begin
        grant_any_o    = 1'b1;
        grant_o[cand]  = 1'b1;
        grant_idx_o    = cand[N_REDUCER_SIZE-1:0];
      end
    end
  end

endmodule

// File: rtl/patch_row_sum_collector.sv
// Collects one-cycle row-sum pulses from the patch reducers into per-reducer
// capture slots and serialises them round-robin onto a valid/ack output word.
module patch_row_sum_collector
  import patch_row_sum_collector_pkg::*;
#(
  parameter int FP_SIZE         = PRSC_FP_SIZE,
  parameter int N_PATCH_REDUCER = PRSC_N_REDUCER,
  parameter int N_REDUCER_SIZE  = log2_ceil(N_PATCH_REDUCER)
) (
  input  logic                               dram_clk,
  input  logic                               reset,
  input  logic [N_PATCH_REDUCER-1:0]         sum_rdy,
  input  logic [N_PATCH_REDUCER*FP_SIZE-1:0] sums,
  output logic                               out_valid,
  output logic [FP_SIZE-1:0]                 out_sum,
  output logic [N_REDUCER_SIZE-1:0]          out_id,
  input  logic                               out_ack,
  output logic                               overflow,
  output logic                               idle
);

  localparam logic [N_REDUCER_SIZE-1:0] LAST_IDX = N_REDUCER_SIZE'(N_PATCH_REDUCER - 1);

  logic [FP_SIZE-1:0]         slot_q [N_PATCH_REDUCER];
  logic [FP_SIZE-1:0]         slot_d [N_PATCH_REDUCER];
  logic [N_PATCH_REDUCER-1:0] pending_q, pending_d;
  logic [N_REDUCER_SIZE-1:0]  rr_ptr_q, rr_ptr_d;
  logic                       out_valid_q, out_valid_d;
  logic [FP_SIZE-1:0]         out_sum_q, out_sum_d;
  logic [N_REDUCER_SIZE-1:0]  out_id_q, out_id_d;
  logic                       overflow_q, overflow_d;

  logic [N_PATCH_REDUCER-1:0] grant;
  logic [N_REDUCER_SIZE-1:0]  grant_idx;
  logic                       grant_any;
  logic                       grant_ok;
  logic                       do_grant;

  rr_arbiter #(
    .N_PATCH_REDUCER (N_PATCH_REDUCER),
    .N_REDUCER_SIZE  (N_REDUCER_SIZE)
  ) u_arb (
    .pending_i   (pending_q),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  always_comb begin
    grant_ok    = !out_valid_q || out_ack;
    do_grant    = grant_ok && grant_any;
    pending_d   = pending_q;
    slot_d      = slot_q;
    overflow_d  = overflow_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_id_d    = out_id_q;

    // A slot granted this cycle is free again, so a same-cycle pulse reloads it without loss.
    for (int i = 0; i < N_PATCH_REDUCER; i++) begin
      if (do_grant && grant[i]) pending_d[i] = 1'b0;
      if (sum_rdy[i]) begin
        if (!pending_q[i] || (do_grant && grant[i])) begin
          slot_d[i]    = sums[i*FP_SIZE +: FP_SIZE];
          pending_d[i] = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end

    if (do_grant) begin
      out_valid_d = 1'b1;
      out_sum_d   = slot_q[grant_idx];
      out_id_d    = grant_idx;
      rr_ptr_d    = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end else if (out_ack) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge dram_clk) begin
    if (reset) begin
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_id_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_id_q    <= out_id_d;
      overflow_q  <= overflow_d;
    end
  end

  // Slot payloads are qualified by pending_q, so they carry no reset.
  always_ff @(posedge dram_clk) begin
    slot_q <= slot_d;
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_id    = out_id_q;
  assign overflow  = overflow_q;
  assign idle      = (pending_q == '0) && !out_valid_q;

endmodule

// File: tb/tb_patch_row_sum_collector.sv
// Bench for patch_row_sum_collector: vector table, directed corner sequences,
// and randomized traffic checked cycle-by-cycle against a behavioural model.
module tb_patch_row_sum_collector;

  localparam int FP = 32;
  localparam int N  = 4;
  localparam int W  = 2;

  logic            dram_clk = 1'b0;
  logic            reset;
  logic [N-1:0]    sum_rdy;
  logic [N*FP-1:0] sums;
  logic            out_valid;
  logic [FP-1:0]   out_sum;
  logic [W-1:0]    out_id;
  logic            out_ack;
  logic            overflow;
  logic            idle;

  int total = 0;
  int bad   = 0;

  always #5 dram_clk = ~dram_clk;

  patch_row_sum_collector #(
    .FP_SIZE         (FP),
    .N_PATCH_REDUCER (N),
    .N_REDUCER_SIZE  (W)
  ) dut (
    .dram_clk  (dram_clk),
    .reset     (reset),
    .sum_rdy   (sum_rdy),
    .sums      (sums),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_id    (out_id),
    .out_ack   (out_ack),
    .overflow  (overflow),
    .idle      (idle)
  );

  // Behavioural model: slots as arrays, output word, round-robin pointer.
  logic          m_pend [N];
  logic [FP-1:0] m_val  [N];
  logic          m_valid;
  logic [FP-1:0] m_sum;
  logic [W-1:0]  m_id;
  int            m_rr;
  logic          m_ovf;
  logic [W+FP-1:0] dlv[$];

  function automatic logic model_idle();
    for (int i = 0; i < N; i++) if (m_pend[i]) return 1'b0;
    return !m_valid;
  endfunction

  task automatic model_step();
    int g;
    if (reset) begin
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0; m_sum = '0; m_id = '0; m_rr = 0; m_ovf = 1'b0;
      return;
    end
    g = -1;
    if (!m_valid || out_ack) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (g < 0 && m_pend[j]) g = j;
      end
    end
    if (g >= 0) begin
      m_sum = m_val[g]; m_id = W'(g); m_valid = 1'b1; m_rr = (g + 1) % N; m_pend[g] = 1'b0;
    end else if (out_ack) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (sum_rdy[i]) begin
        if (!m_pend[i]) begin m_val[i] = sums[i*FP +: FP]; m_pend[i] = 1'b1; end
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    if (!reset && out_valid && out_ack) dlv.push_back({out_id, out_sum});
    model_step();
    @(posedge dram_clk);
    #1;
    check("model", 64'({out_valid, overflow, idle, out_id, out_sum}),
          64'({m_valid, m_ovf, model_idle(), m_id, m_sum}));
  endtask

  task automatic drive(input logic r, input logic [N-1:0] rd, input logic [N*FP-1:0] s, input logic a);
    reset = r; sum_rdy = rd; sums = s; out_ack = a;
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    sum_rdy = '0; out_ack = 1'b1;
    while (!idle && c < maxc) begin tick(); c++; end
    check("drain_done", 64'(idle), 64'(1));
  endtask

  typedef struct {
    logic            rst;
    logic [N-1:0]    rdy;
    logic [N*FP-1:0] sm;
    logic            ack;
    logic            ev;
    logic [W-1:0]    eid;
    logic [FP-1:0]   esum;
    logic            eovf;
    logic            eidle;
  } vec_t;

  vec_t tbl [12];

  localparam logic [N*FP-1:0] S1 = 128'h00000000_00000000_3F800000_00000000;
  localparam logic [N*FP-1:0] S4 = 128'h00000044_00000033_00000022_00000011;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin m_pend[i] = 1'b0; m_val[i] = '0; end
    m_valid = 1'b0; m_sum = '0; m_id = '0; m_rr = 0; m_ovf = 1'b0;
    drive(1'b1, '0, '0, 1'b0);

    //            rst   rdy      sums ack   ev  eid    esum          eovf  eidle
    tbl[0]  = '{1'b1, 4'b1111, S4, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b1};
    tbl[1]  = '{1'b0, 4'b0010, S1, 1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, '0, 1'b1, 1'b1, 2'd1, 32'h3F800000, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, '0, 1'b1, 1'b0, 2'd1, 32'h3F800000, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 4'b0000, '0, 1'b1, 1'b0, 2'd1, 32'h3F800000, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 4'b1111, S4, 1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 1'b1};
    tbl[6]  = '{1'b0, 4'b1111, S4, 1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, '0, 1'b1, 1'b1, 2'd0, 32'h11,       1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'b0000, '0, 1'b1, 1'b1, 2'd1, 32'h22,       1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'b0000, '0, 1'b1, 1'b1, 2'd2, 32'h33,       1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, '0, 1'b1, 1'b1, 2'd3, 32'h44,       1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'b0000, '0, 1'b1, 1'b0, 2'd3, 32'h44,       1'b0, 1'b1};

    for (int v = 0; v < 12; v++) begin
      drive(tbl[v].rst, tbl[v].rdy, tbl[v].sm, tbl[v].ack);
      tick();
      check($sformatf("vec%0d_valid", v), 64'(out_valid), 64'(tbl[v].ev));
      check($sformatf("vec%0d_id", v),    64'(out_id),    64'(tbl[v].eid));
      check($sformatf("vec%0d_sum", v),   64'(out_sum),   64'(tbl[v].esum));
      check($sformatf("vec%0d_ovf", v),   64'(overflow),  64'(tbl[v].eovf));
      check($sformatf("vec%0d_idle", v),  64'(idle),      64'(tbl[v].eidle));
    end

    // Back-pressure: output held, two more sums arrive and wait.
    drive(1'b1, '0, '0, 1'b0); tick(); dlv.delete();
    drive(1'b0, 4'b0001, {96'h0, 32'hA0A0A0A0}, 1'b0); tick();
    drive(1'b0, 4'b0000, '0, 1'b0); tick();
    check("bp_valid", 64'(out_valid), 64'(1));
    for (int k = 0; k < 10; k++) begin
      if (k == 2) drive(1'b0, 4'b1100, {32'hC0C0C0C0, 32'hB0B0B0B0, 64'h0}, 1'b0);
      else        drive(1'b0, 4'b0000, '0, 1'b0);
      tick();
      check("bp_hold", 64'({out_valid, out_id, out_sum}), 64'({1'b1, 2'd0, 32'hA0A0A0A0}));
    end
    drain(20);
    check("bp_count", 64'(dlv.size()), 64'(3));
    if (dlv.size() == 3) begin
      check("bp_w0", 64'(dlv[0]), 64'({2'd0, 32'hA0A0A0A0}));
      check("bp_w1", 64'(dlv[1]), 64'({2'd2, 32'hB0B0B0B0}));
      check("bp_w2", 64'(dlv[2]), 64'({2'd3, 32'hC0C0C0C0}));
    end
    check("bp_ovf", 64'(overflow), 64'(0));

    // Loss: output occupied, reducer 2 pulses twice 5 cycles apart.
    drive(1'b1, '0, '0, 1'b0); tick(); dlv.delete();
    drive(1'b0, 4'b0001, {96'h0, 32'h12345678}, 1'b0); tick();
    drive(1'b0, 4'b0000, '0, 1'b0); tick();
    drive(1'b0, 4'b0100, {32'h0, 32'hD1D1D1D1, 64'h0}, 1'b0); tick();
    drive(1'b0, 4'b0000, '0, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    check("loss_ovf_before", 64'(overflow), 64'(0));
    drive(1'b0, 4'b0100, {32'h0, 32'hD2D2D2D2, 64'h0}, 1'b0); tick();
    drive(1'b0, 4'b0000, '0, 1'b0); tick();
    check("loss_ovf", 64'(overflow), 64'(1));
    drain(20);
    check("loss_count", 64'(dlv.size()), 64'(2));
    if (dlv.size() == 2) begin
      check("loss_w0", 64'(dlv[0]), 64'({2'd0, 32'h12345678}));
      check("loss_w1", 64'(dlv[1]), 64'({2'd2, 32'hD1D1D1D1}));
    end
    for (int k = 0; k < 3; k++) tick();
    check("loss_ovf_sticky", 64'(overflow), 64'(1));

    // Same-cycle grant of slot 0 and a new pulse on reducer 0.
    drive(1'b1, '0, '0, 1'b1); tick(); dlv.delete();
    drive(1'b0, 4'b0001, {96'h0, 32'hE0E0E0E0}, 1'b1); tick();
    drive(1'b0, 4'b0001, {96'h0, 32'hF0F0F0F0}, 1'b1); tick();
    check("same_w0_out", 64'({out_valid, out_sum}), 64'({1'b1, 32'hE0E0E0E0}));
    drain(20);
    check("same_count", 64'(dlv.size()), 64'(2));
    if (dlv.size() == 2) begin
      check("same_w0", 64'(dlv[0]), 64'({2'd0, 32'hE0E0E0E0}));
      check("same_w1", 64'(dlv[1]), 64'({2'd0, 32'hF0F0F0F0}));
    end
    check("same_ovf", 64'(overflow), 64'(0));

    // Reset mid-operation with three slots pending.
    drive(1'b0, 4'b1111, S4, 1'b0); tick();
    drive(1'b0, 4'b0000, '0, 1'b0); tick();
    check("rst_busy", 64'({out_valid, idle}), 64'({1'b1, 1'b0}));
    drive(1'b1, 4'b1111, S4, 1'b0); tick();
    check("rst_clear", 64'({out_valid, idle, out_sum}), 64'({1'b1 ^ 1'b1, 1'b1, 32'h0}));
    drive(1'b0, 4'b0000, '0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rst_quiet", 64'({out_valid, idle}), 64'({1'b0, 1'b1}));
    end
    drive(1'b0, 4'b0010, S1, 1'b1); tick();
    check("rst_new_lat1", 64'(out_valid), 64'(0));
    drive(1'b0, 4'b0000, '0, 1'b1); tick();
    check("rst_new_lat2", 64'({out_valid, out_id, out_sum}), 64'({1'b1, 2'd1, 32'h3F800000}));

    // Randomized traffic against the model.
    drive(1'b1, '0, '0, 1'b0); tick();
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] rd;
      for (int i = 0; i < N; i++) rd[i] = ($urandom_range(3) == 0);
      drive(($urandom_range(149) == 0), rd,
            {$urandom(), $urandom(), $urandom(), $urandom()},
            ($urandom_range(3) != 0));
      tick();
    end
    drain(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
